clint_mh: RTL and testbench

CLINT_MH -- requirements
Module: clint_mh

---
 rtl/clint_pkg.sv | 9 +
 rtl/clint_tick_gen.sv | 16 +
 rtl/clint_mh.sv | 102 ++++++++++
 tb/tb_clint_mh.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: CLINT register map constants and the 64-bit time type
package clint_pkg;
  localparam logic [15:0] MSIP_BASE = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_ADDR = 16'hBFF8;
  localparam logic [15:0] MTIMEH_ADDR = 16'hBFFC;
  localparam int MAX_HARTS = 16;
  typedef logic [63:0] mtime_t;
endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: mtime prescaler, one tick every TICK_DIV cycles, restarted by clr_i
module clint_tick_gen import clint_pkg::*; #(
  parameter int TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  logic [15:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == 16'(TICK_DIV - 1);
  assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 16'd1;
  always_ff @(posedge clk_i) begin
    cnt_q <= rst_i ? '0 : cnt_d;
  end
endmodule

// File: rtl/clint_mh.sv
// clint_mh: multi-hart CLINT (msip, mtimecmp, mtime); CLINT_TICK_DIV_EN enables the mtime prescaler
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO
`define ZERO '0
`endif
module clint_mh import clint_pkg::*; #(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [`DATA_WIDTH-1:0] addr_i,
  input  logic [`DATA_WIDTH-1:0] data_i,
  output logic [`DATA_WIDTH-1:0] data_o,
  output logic                   ack_o,
  output logic [NUM_HARTS-1:0]   timer_irq_o,
  output logic [NUM_HARTS-1:0]   software_irq_o
);
  logic [15:0] a, ms_off, cmp_off;
  logic aligned, wr, msip_sel, cmp_sel, mtl_sel, mth_sel, mt_we, tick, ack_q;
  logic [NUM_HARTS-1:0] msip_q, msip_d, tirq_d, tirq_q, sirq_q;
  logic [`DATA_WIDTH-1:0] rdata, data_q;
  mtime_t mtime_q, mtime_d;
  mtime_t cmp_q [NUM_HARTS];
  mtime_t cmp_d [NUM_HARTS];
  logic unused_addr;
  assign unused_addr = ^addr_i[`DATA_WIDTH-1:16];
  assign a = addr_i[15:0];
  assign ms_off = a - MSIP_BASE;
  assign cmp_off = a - MTIMECMP_BASE;
  assign aligned = a[1:0] == 2'b00;
  assign wr = req_i & we_i;
  assign msip_sel = aligned && a < MTIMECMP_BASE && 32'(ms_off[15:2]) < NUM_HARTS;
  assign cmp_sel = aligned && a >= MTIMECMP_BASE && 32'(cmp_off[15:3]) < NUM_HARTS;
  assign mtl_sel = a == MTIME_ADDR;
  assign mth_sel = a == MTIMEH_ADDR;
  assign mt_we = wr & (mtl_sel | mth_sel);
`ifdef CLINT_TICK_DIV_EN
  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (mt_we),
    .tick_o(tick)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^16'(TICK_DIV);
  assign tick = 1'b1;
`endif
  // Software writes to mtime replace the increment for that edge
  always_comb begin
    rdata = `ZERO;
    msip_d = msip_q;
    cmp_d = cmp_q;
    mtime_d = mt_we ? mtime_q : mtime_q + 64'(tick);
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_sel && 32'(ms_off[15:2]) == h) begin
        rdata = {31'b0, msip_q[h]};
        if (wr) msip_d[h] = data_i[0];
      end
      if (cmp_sel && 32'(cmp_off[15:3]) == h) begin
        rdata = cmp_off[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
        if (wr && cmp_off[2]) cmp_d[h][63:32] = data_i;
        if (wr && !cmp_off[2]) cmp_d[h][31:0] = data_i;
      end
    end
    if (mtl_sel) rdata = mtime_q[31:0];
    if (mth_sel) rdata = mtime_q[63:32];
    if (wr && mtl_sel) mtime_d[31:0] = data_i;
    if (wr && mth_sel) mtime_d[63:32] = data_i;
  end
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_cmp
    assign tirq_d[g] = mtime_q >= cmp_q[g];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
      msip_q <= '0;
      ack_q <= 1'b0;
      data_q <= `ZERO;
      tirq_q <= '0;
      sirq_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      msip_q <= msip_d;
      ack_q <= req_i;
      data_q <= (req_i && !we_i) ? rdata : `ZERO;
      tirq_q <= tirq_d;
      sirq_q <= msip_q;
    end
  end
  assign data_o = data_q;
  assign ack_o = ack_q;
  assign timer_irq_o = tirq_q;
  assign software_irq_o = sirq_q;
endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: scoreboard bench for a two-hart clint_mh
module tb_clint_mh;
  import clint_pkg::*;
  localparam int NH = 2;
  localparam int TDIV = 4;
  typedef struct {
    logic        rd;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic ack;
  logic [NH-1:0] tirq, sirq;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  mtime_t m;
  mtime_t cmp_m [NH];
  logic [NH-1:0] msip_m, tirq_m, sirq_m;
  logic req_prev = 1'b0;
  int pc;
  logic tick_m, mwr;
  always #5 clk = ~clk;
  clint_mh #(.NUM_HARTS(NH), .TICK_DIV(TDIV)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_o), .ack_o(ack), .timer_irq_o(tirq), .software_irq_o(sirq)
  );
`ifdef CLINT_TICK_DIV_EN
  assign tick_m = pc == TDIV - 1;
`else
  assign tick_m = 1'b1;
`endif
  assign mwr = req && we && (addr == 32'hBFF8 || addr == 32'hBFFC);
  // Reference model of the register file and interrupt outputs
  always @(posedge clk) begin
    if (rst) begin
      m <= '0;
      for (int h = 0; h < NH; h++) cmp_m[h] <= '1;
      msip_m <= '0;
      tirq_m <= '0;
      sirq_m <= '0;
      req_prev <= 1'b0;
      pc <= 0;
    end else begin
      req_prev <= req;
      for (int h = 0; h < NH; h++) tirq_m[h] <= m >= cmp_m[h];
      sirq_m <= msip_m;
      pc <= (mwr || tick_m) ? 0 : pc + 1;
      m <= mwr ? m : m + 64'(tick_m);
      if (req && we) begin
        case (addr)
          32'h0000: msip_m[0] <= wdata[0];
          32'h0004: msip_m[1] <= wdata[0];
          32'h4000: cmp_m[0][31:0] <= wdata;
          32'h4004: cmp_m[0][63:32] <= wdata;
          32'h4008: cmp_m[1][31:0] <= wdata;
          32'h400C: cmp_m[1][63:32] <= wdata;
          32'hBFF8: m[31:0] <= wdata;
          32'hBFFC: m[63:32] <= wdata;
          default: ;
        endcase
      end
    end
  end
  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h0000: return {31'b0, msip_m[0]};
      32'h0004: return {31'b0, msip_m[1]};
      32'h4000: return cmp_m[0][31:0];
      32'h4004: return cmp_m[0][63:32];
      32'h4008: return cmp_m[1][31:0];
      32'h400C: return cmp_m[1][63:32];
      32'hBFF8: return m[31:0];
      32'hBFFC: return m[63:32];
      default:  return 32'h0;
    endcase
  endfunction
  // Every request must be acked one cycle later; read data is popped from the scoreboard
  always @(negedge clk) begin
    total++;
    if (ack !== req_prev) begin
      bad++;
      $display("FAIL ack_timing: got %b want %b at %0t", ack, req_prev, $time);
    end
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: ack with no pending request at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.rd) begin
          total++;
          if (data_o !== mon_e.exp) begin
            bad++;
            $display("FAIL read_data: got %h want %h at %0t", data_o, mon_e.exp, $time);
          end
        end
      end
    end else begin
      total++;
      if (data_o !== 32'h0) begin
        bad++;
        $display("FAIL idle_data: got %h want 0 at %0t", data_o, $time);
      end
    end
  end
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    exp_t x;
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    x.rd = !w;
    x.exp = e;
    sb.push_back(x);
    @(negedge clk);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 32'h0);
  endtask
  task automatic rd(input logic [31:0] a);
    issue(1'b0, a, 32'h0, model_read(a));
  endtask
  task automatic rdx(input logic [31:0] a, input logic [31:0] e);
    issue(1'b0, a, 32'h0, e);
  endtask
  task automatic idle(input int n);
    req = 1'b0;
    we = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 1'b1;
    addr = 32'hBFF8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    total += 4;
    if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
    if (tirq !== 2'b00) begin bad++; $display("FAIL reset_tirq: got %b want 00", tirq); end
    if (sirq !== 2'b00) begin bad++; $display("FAIL reset_sirq: got %b want 00", sirq); end
  endtask
  task automatic test_mtime_read();
    idle(10);
`ifdef CLINT_TICK_DIV_EN
    rd(32'hBFF8);
`else
    rdx(32'hBFF8, 32'd10);
`endif
    rdx(32'hBFFC, 32'h0);
    idle(1);
    total += 2;
    if (tirq !== 2'b00) begin bad++; $display("FAIL idle_tirq: got %b want 00", tirq); end
    if (sirq !== 2'b00) begin bad++; $display("FAIL idle_sirq: got %b want 00", sirq); end
  endtask
  task automatic test_timer();
    wr(32'hBFF8, 32'h0);
    wr(32'hBFFC, 32'h0);
    wr(32'h4008, 32'd20);
    wr(32'h400C, 32'h0);
    req = 1'b0;
    for (int i = 0; i < 30 * TDIV; i++) begin
      @(negedge clk);
      total++;
      if (tirq !== tirq_m) begin bad++; $display("FAIL timer_irq: got %b want %b (mtime %0d)", tirq, tirq_m, m); end
    end
    total++;
    if (tirq !== 2'b10) begin bad++; $display("FAIL timer_final: got %b want 10", tirq); end
    wr(32'h400C, 32'h1);
    idle(2);
    total++;
    if (tirq !== 2'b00) begin bad++; $display("FAIL timer_clear: got %b want 00", tirq); end
  endtask
  task automatic test_software();
    wr(32'h0004, 32'hFFFF_FFFF);
    rdx(32'h0004, 32'h1);
    total++;
    if (sirq !== 2'b10) begin bad++; $display("FAIL sw_set: got %b want 10", sirq); end
    wr(32'h0004, 32'h0);
    total++;
    if (sirq !== 2'b10) begin bad++; $display("FAIL sw_hold: got %b want 10", sirq); end
    idle(1);
    total++;
    if (sirq !== 2'b00) begin bad++; $display("FAIL sw_clear: got %b want 00", sirq); end
    rdx(32'h0004, 32'h0);
    idle(1);
  endtask
  task automatic test_carry();
    wr(32'hBFF8, 32'hFFFF_FFFE);
    wr(32'hBFFC, 32'h0);
`ifdef CLINT_TICK_DIV_EN
    idle(2 * TDIV);
    rd(32'hBFF8);
    rd(32'hBFFC);
`else
    idle(2);
    rdx(32'hBFF8, 32'h0);
    rdx(32'hBFFC, 32'h1);
`endif
    idle(1);
  endtask
  task automatic test_unmapped();
    rdx(32'h0008, 32'h0);
    wr(32'h0008, 32'h1);
    rdx(32'h0008, 32'h0);
    rdx(32'h0000, 32'h0);
    rdx(32'h0004, 32'h0);
    wr(32'h4001, 32'h0);
    rdx(32'h4000, 32'hFFFF_FFFF);
    rdx(32'h4010, 32'h0);
    rdx(32'h1234, 32'h0);
    idle(2);
    total++;
    if (sirq !== 2'b00) begin bad++; $display("FAIL unmapped_sirq: got %b want 00", sirq); end
  endtask
  task automatic test_back_to_back();
    wr(32'h4000, 32'd5);
    rdx(32'h4000, 32'd5);
    wr(32'h4004, 32'h0);
    rdx(32'h4004, 32'h0);
    rd(32'hBFF8);
    rd(32'hBFFC);
    idle(2);
    total++;
    if (tirq[0] !== 1'b1) begin bad++; $display("FAIL b2b_tirq0: got %b want 1", tirq[0]); end
  endtask
`ifdef CLINT_TICK_DIV_EN
  task automatic test_tickdiv();
    wr(32'hBFF8, 32'h0);
    wr(32'hBFFC, 32'h0);
    idle(40);
    rdx(32'hBFF8, 32'd10);
    idle(1);
    wr(32'hBFF8, 32'd100);
    idle(2);
    rdx(32'hBFF8, 32'd100);
    rdx(32'hBFF8, 32'd100);
    rdx(32'hBFF8, 32'd101);
    idle(2);
  endtask
`endif
  initial begin
    test_reset();
    test_mtime_read();
    test_timer();
    test_software();
    test_carry();
    test_unmapped();
    test_back_to_back();
`ifdef CLINT_TICK_DIV_EN
    test_tickdiv();
`endif
    idle(2);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
